prim_fifo_sync_cnt: RTL and testbench
=====================================

Name: prim_fifo_sync_cnt

Overview:
- Parameterised single-clock synchronous FIFO with a ready/valid handshake on both sides and an occupancy count output.
- Sits directly downstream of the utility package and is its first consumer: all pointer and count widths come from vbits(), so Depth=1 and non-power-of-two depths size correctly.
- Serves as the general buffering stage between producer and consumer pipelines in the design.

Parameters:
- Width, 16, data word width in bits (≥1).
- Depth, 4, number of storage entries (≥1; need not be a power of two).
- PtrW (localparam), vbits(Depth), read/write pointer index width.
- DepthW (localparam), vbits(Depth+1), width of the occupancy count so that the value Depth fits.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  reset, asynchronous and active-low.
- clr_i  input  1  synchronous flush.
- wvalid_i  input  1  producer has data.
- wready_o  output  1  FIFO accepts data this cycle.
- wdata_i  input  Width  write data.
- rvalid_o  output  1  FIFO presents valid data.
- rready_i  input  1  consumer takes data this cycle.
- rdata_o  output  Width  read data.
- full_o  output  1  occupancy == Depth.
- depth_o  output  DepthW  current occupancy, 0..Depth.

Behaviour:
- Reset (rst_ni low, asynchronous):
  - Write pointer, read pointer and count clear to 0.
  - Outputs: depth_o=0, full_o=0, rvalid_o=0, wready_o=1, rdata_o=0.
  - Storage array is not reset.
- Push occurs when wvalid_i & wready_o; pop occurs when rvalid_o & rready_i.
- Default (no macro):
  - wready_o = !full & !clr_i.
  - rvalid_o = (count!=0) & !clr_i.
  - rdata_o = storage[rptr] when count!=0, else 0.
- Latency: a push in cycle N makes the word visible on rdata_o with rvalid_o=1 in cycle N+1. No combinational path from wvalid_i to rvalid_o.
- Pointers:
  - Increment modulo Depth: the value Depth-1 wraps to 0.
  - For Depth=1 the single pointer stays 0.
  - Count is tracked explicitly, not derived from pointer difference.
- Count update: push only → +1; pop only → −1; push and pop together → unchanged, both pointers advance.
- Full: wready_o=0. A simultaneous pop still happens and the new write is not taken; wready_o returns to 1 the next cycle.
- Empty: rvalid_o=0, no pop; a push is accepted normally.
- clr_i:
  - Takes priority over push and pop in the same cycle; both are suppressed.
  - Pointers and count are 0 the next cycle.
  - Storage contents remain but are unreachable.
- Asynchronous reset mid-operation aborts any in-flight transfer. No push or pop completes on that edge.
- Handshake rules:
  - Producer must hold wdata_i stable while wvalid_i=1 and wready_o=0.
  - FIFO holds rdata_o and rvalid_o stable until a pop or clr_i occurs.
- Assertions (simulation only): Depth≥1; count never exceeds Depth; no push while full; no pop while empty.

Optional Feature:
- Macro: PRIM_FIFO_PASSTHRU_EN.
- Defined:
  - When count==0, rvalid_o = wvalid_i & !clr_i and rdata_o = wdata_i (zero-latency bypass).
  - If empty and wvalid_i & rready_i, the word passes straight through. Storage, pointers and depth_o are untouched (stays 0).
  - If empty and wvalid_i & !rready_i, the word is stored normally and depth_o becomes 1.
- Undefined: default one-cycle latency behaviour above; rdata_o=0 when empty.

Test Plan:
- Reset then idle, Depth=4 → depth_o=0, full_o=0, wready_o=1, rvalid_o=0, rdata_o=0.
- Push 0x0001..0x0004 with rready_i=0 → depth_o counts 1,2,3,4; full_o=1 and wready_o=0 after the 4th push; a 5th wvalid_i is not accepted. Pop all four → 0x0001..0x0004 in order, depth_o back to 0.
- Continuous push+pop for 10 cycles with Depth=3 (non-power-of-two wrap) → output sequence equals input, depth_o constant at 1 after the first cycle.
- FIFO full (Depth=4) with wvalid_i=1 and rready_i=1 → pop occurs, push rejected, depth_o=3 next cycle, then the push is accepted.
- clr_i asserted with depth_o=2 and wvalid_i=1 → both suppressed; next cycle depth_o=0, rvalid_o=0.
- Depth=1 build → DepthW=1, PtrW=1; push 0xABCD makes full_o=1, depth_o=1. With PRIM_FIFO_PASSTHRU_EN on an empty FIFO, wvalid_i&rready_i with 0x1234 gives rdata_o=0x1234 in the same cycle and depth_o stays 0.

Source files
------------

// File: rtl/prim_fifo_sync_cnt.sv
// prim_fifo_sync_cnt: single-clock ready/valid FIFO with an explicit occupancy count.
// Pointer and count widths follow vbits(): vbits(n) = (n <= 1) ? 1 : $clog2(n),
// so Depth=1 and non-power-of-two depths are sized correctly.
// Optional macro PRIM_FIFO_PASSTHRU_EN: zero-latency bypass while the FIFO is empty.
module prim_fifo_sync_cnt #(
  parameter  int unsigned Width  = 16,
  parameter  int unsigned Depth  = 4,
  localparam int unsigned PtrW   = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned DepthW = ((Depth + 1) > 1) ? $clog2(Depth + 1) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              wvalid_i,
  output logic              wready_o,
  input  logic [Width-1:0]  wdata_i,
  output logic              rvalid_o,
  input  logic              rready_i,
  output logic [Width-1:0]  rdata_o,
  output logic              full_o,
  output logic [DepthW-1:0] depth_o
);

  logic [Width-1:0]  storage [Depth];
  logic [PtrW-1:0]   wptr_reg;
  logic [PtrW-1:0]   rptr_reg;
  logic [DepthW-1:0] count_reg;

  logic empty;
  logic full;
  logic push;
  logic pop;
  logic bypass;
  logic do_push;
  logic do_pop;

  // Pointers wrap at Depth-1 rather than at a power of two; Depth=1 pins them at 0.
  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
    if (ptr == PtrW'(Depth - 1)) begin
      return '0;
    end
    return ptr + PtrW'(1);
  endfunction

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == DepthW'(Depth));
  assign full_o  = full;
  assign depth_o = count_reg;

  // A flush blocks both sides in the cycle it is asserted.
  assign wready_o = !full & !clr_i;

`ifdef PRIM_FIFO_PASSTHRU_EN
  // Empty FIFO forwards the producer word directly; it is only stored if the consumer stalls.
  assign rvalid_o = clr_i ? 1'b0 : (empty ? wvalid_i : 1'b1);
  assign rdata_o  = empty ? wdata_i : storage[rptr_reg];
  assign bypass   = empty & wvalid_i & rready_i & !clr_i;
`else
  assign rvalid_o = !empty & !clr_i;
  assign rdata_o  = empty ? '0 : storage[rptr_reg];
  assign bypass   = 1'b0;
`endif

  assign push    = wvalid_i & wready_o;
  assign pop     = rvalid_o & rready_i;
  // A bypassed word neither enters nor leaves storage.
  assign do_push = push & !bypass;
  assign do_pop  = pop & !bypass;

  // Pointer and count state: flush wins over push/pop, count is tracked explicitly.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
    end else if (clr_i) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (do_push) begin
        wptr_reg <= next_ptr(wptr_reg);
      end
      if (do_pop) begin
        rptr_reg <= next_ptr(rptr_reg);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + DepthW'(1);
        2'b01:   count_reg <= count_reg - DepthW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage write port; contents are never reset, only made unreachable by pointers.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      storage[wptr_reg] <= wdata_i;
    end
  end

`ifndef SYNTHESIS
  a_depth_min : assert property (@(posedge clk_i) Depth >= 1);
  a_count_max : assert property (@(posedge clk_i) disable iff (!rst_ni)
                                 count_reg <= DepthW'(Depth));
  a_no_push_full : assert property (@(posedge clk_i) disable iff (!rst_ni)
                                    !(do_push && full));
  a_no_pop_empty : assert property (@(posedge clk_i) disable iff (!rst_ni)
                                    !(do_pop && empty));
`endif

endmodule

// File: tb/tb_prim_fifo_sync_cnt.sv
// Self-checking bench for prim_fifo_sync_cnt: three instances (Depth 4, 3, 1),
// each shadowed by a queue-based model checked every negative clock edge.
module tb_prim_fifo_sync_cnt;
  localparam int W  = 16;
  localparam int NI = 3;
  localparam int DEP [NI] = '{4, 3, 1};
`ifdef PRIM_FIFO_PASSTHRU_EN
  localparam bit PT = 1'b1;
`else
  localparam bit PT = 1'b0;
`endif

  logic         clk_i  = 1'b0;
  logic         rst_ni = 1'b0;
  logic         clr    [NI];
  logic         wvalid [NI];
  logic         rready [NI];
  logic [W-1:0] wdata  [NI];
  logic         wready [NI];
  logic         rvalid [NI];
  logic         full   [NI];
  logic [W-1:0] rdata  [NI];
  logic [2:0]   depth  [NI];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input int inst, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s inst%0d: got 0x%0h required 0x%0h at %0t", nm, inst, act, exp, $time);
  endtask

  for (genvar gi = 0; gi < NI; gi++) begin : g_inst
    localparam int D  = DEP[gi];
    localparam int DW = ((D + 1) > 1) ? $clog2(D + 1) : 1;
    logic [DW-1:0] depth_w;

    prim_fifo_sync_cnt #(.Width(W), .Depth(D)) u_dut (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .clr_i    (clr[gi]),
      .wvalid_i (wvalid[gi]),
      .wready_o (wready[gi]),
      .wdata_i  (wdata[gi]),
      .rvalid_o (rvalid[gi]),
      .rready_i (rready[gi]),
      .rdata_o  (rdata[gi]),
      .full_o   (full[gi]),
      .depth_o  (depth_w)
    );
    assign depth[gi] = 3'(depth_w);

    // Reference model: the FIFO contents as a plain queue of words.
    logic [W-1:0] q[$];
    int           m_cnt;
    bit           m_wr, m_rv, m_byp;

    always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        q.delete();
      end else if (clr[gi]) begin
        q.delete();
      end else begin
        m_cnt = q.size();
        m_wr  = (m_cnt != D);
        m_rv  = (m_cnt != 0) || (PT && wvalid[gi]);
        m_byp = PT && (m_cnt == 0) && wvalid[gi] && rready[gi];
        if (!m_byp) begin
          if (m_rv && rready[gi]) void'(q.pop_front());
          if (m_wr && wvalid[gi]) q.push_back(wdata[gi]);
        end
      end
    end

    int           c_cnt;
    logic [W-1:0] c_rdata;
    bit           c_rv;

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk_i) begin
      c_cnt   = q.size();
      c_rv    = !clr[gi] && ((c_cnt != 0) || (PT && wvalid[gi]));
      c_rdata = (c_cnt != 0) ? q[0] : (PT ? wdata[gi] : '0);
      chk("m_depth",  gi, 32'(depth[gi]),  32'(c_cnt));
      chk("m_full",   gi, 32'(full[gi]),   32'(c_cnt == D));
      chk("m_wready", gi, 32'(wready[gi]), 32'((c_cnt != D) && !clr[gi]));
      chk("m_rvalid", gi, 32'(rvalid[gi]), 32'(c_rv));
      chk("m_rdata",  gi, 32'(rdata[gi]),  32'(c_rdata));
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  logic [W-1:0] got[$];
  bit           hold [NI];

  initial begin
    for (int i = 0; i < NI; i++) begin
      clr[i] = 1'b0; wvalid[i] = 1'b0; rready[i] = 1'b0; wdata[i] = '0;
    end
    repeat (3) @(posedge clk_i);
    #2 rst_ni = 1'b1;
    step();

    // Reset / idle state.
    chk("rst_depth", 0, 32'(depth[0]), 0);
    chk("rst_full", 0, 32'(full[0]), 0);
    chk("rst_wready", 0, 32'(wready[0]), 1);
    chk("rst_rvalid", 0, 32'(rvalid[0]), 0);
    chk("rst_rdata", 0, 32'(rdata[0]), 0);

    // Fill Depth=4 with 1..4, then try a 5th word.
    for (int k = 1; k <= 4; k++) begin
      wvalid[0] = 1'b1; wdata[0] = W'(k);
      step();
      chk("fill_depth", 0, 32'(depth[0]), 32'(k));
    end
    wdata[0] = 16'h0005;
    #1;
    chk("fill_full", 0, 32'(full[0]), 1);
    chk("fill_wready", 0, 32'(wready[0]), 0);
    step();
    chk("fill_5th_rejected", 0, 32'(depth[0]), 4);
    wvalid[0] = 1'b0;
    rready[0] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      #1;
      chk("drain_rdata", 0, 32'(rdata[0]), 32'(k));
      step();
    end
    rready[0] = 1'b0;
    #1;
    chk("drain_depth", 0, 32'(depth[0]), 0);
    chk("drain_rvalid", 0, 32'(rvalid[0]), 0);

    // Full with simultaneous push and pop: pop happens, push refused.
    for (int k = 0; k < 4; k++) begin
      wvalid[0] = 1'b1; wdata[0] = W'(16'h10 + k);
      step();
    end
    wdata[0] = 16'h0014; rready[0] = 1'b1;
    step();
    chk("fullpp_depth", 0, 32'(depth[0]), 3);
    chk("fullpp_rdata", 0, 32'(rdata[0]), 32'h11);
    rready[0] = 1'b0;
    #1;
    chk("fullpp_wready", 0, 32'(wready[0]), 1);
    step();
    chk("fullpp_retry", 0, 32'(depth[0]), 4);
    wvalid[0] = 1'b0; clr[0] = 1'b1;
    step();
    clr[0] = 1'b0;

    // Flush at depth 2 with a push and pop pending.
    for (int k = 0; k < 2; k++) begin
      wvalid[0] = 1'b1; wdata[0] = W'(16'h20 + k);
      step();
    end
    chk("clr_pre_depth", 0, 32'(depth[0]), 2);
    clr[0] = 1'b1; wdata[0] = 16'h0022; rready[0] = 1'b1;
    #1;
    chk("clr_wready", 0, 32'(wready[0]), 0);
    chk("clr_rvalid", 0, 32'(rvalid[0]), 0);
    step();
    clr[0] = 1'b0; wvalid[0] = 1'b0; rready[0] = 1'b0;
    #1;
    chk("clr_depth", 0, 32'(depth[0]), 0);
    chk("clr_rvalid_after", 0, 32'(rvalid[0]), 0);

    // Depth=3: continuous push+pop across the non-power-of-two wrap.
    wvalid[1] = 1'b1; rready[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wdata[1] = W'(16'h100 + i);
      #1;
      if (rvalid[1]) got.push_back(rdata[1]);
      step();
`ifndef PRIM_FIFO_PASSTHRU_EN
      chk("stream_depth", 1, 32'(depth[1]), 1);
`endif
    end
    wvalid[1] = 1'b0;
    for (int t = 0; t < 20 && got.size() < 10; t++) begin
      #1;
      if (rvalid[1]) got.push_back(rdata[1]);
      step();
    end
    rready[1] = 1'b0;
    chk("stream_count", 1, 32'(got.size()), 10);
    for (int i = 0; i < got.size() && i < 10; i++)
      chk("stream_order", 1, 32'(got[i]), 32'(16'h100 + i));

    // Depth=1 instance.
    wvalid[2] = 1'b1; wdata[2] = 16'hABCD;
    step();
    wdata[2] = 16'h5555;
    #1;
    chk("d1_full", 2, 32'(full[2]), 1);
    chk("d1_depth", 2, 32'(depth[2]), 1);
    chk("d1_rdata", 2, 32'(rdata[2]), 32'hABCD);
    chk("d1_wready", 2, 32'(wready[2]), 0);
    wvalid[2] = 1'b0; rready[2] = 1'b1;
    step();
    rready[2] = 1'b0;
    chk("d1_drained", 2, 32'(depth[2]), 0);
`ifdef PRIM_FIFO_PASSTHRU_EN
    wvalid[2] = 1'b1; rready[2] = 1'b1; wdata[2] = 16'h1234;
    #1;
    chk("pt_rdata", 2, 32'(rdata[2]), 32'h1234);
    chk("pt_rvalid", 2, 32'(rvalid[2]), 1);
    step();
    wvalid[2] = 1'b0; rready[2] = 1'b0;
    chk("pt_depth", 2, 32'(depth[2]), 0);
`endif

    // Randomised traffic on all instances, with one asynchronous reset mid-run.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk_i);
      for (int i = 0; i < NI; i++) hold[i] = wvalid[i] && !wready[i];
      step();
      for (int i = 0; i < NI; i++) begin
        clr[i]    = ($urandom_range(0, 19) == 0);
        rready[i] = ($urandom_range(0, 2) != 0);
        if (!hold[i]) begin
          wvalid[i] = ($urandom_range(0, 2) != 0);
          wdata[i]  = W'($urandom_range(0, 65535));
        end
      end
      if (cyc == 1500) #2 rst_ni = 1'b0;
      if (cyc == 1502) #2 rst_ni = 1'b1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
